// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming encoder family.
// Configuration macro: HAMMING_SECDED_EN. When it is defined, one overall
// even-parity bit is appended as the codeword MSB.
package hamming_pkg;

    localparam int LEGACY_DATA_W = 8;

    // Smallest P with 2^P >= data_w + P + 1.
    function automatic int calc_parity_bits(input int data_w);
        int p;
        p = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << p) < data_w + p + 1) p++;
        end
        return p;
    endfunction

    // Full codeword width, including the overall parity bit when enabled.
    function automatic int calc_code_w(input int data_w);
`ifdef HAMMING_SECDED_EN
        return data_w + calc_parity_bits(data_w) + 1;
`else
        return data_w + calc_parity_bits(data_w);
`endif
    endfunction

    // Hamming positions that are powers of two hold parity bits.
    function automatic logic is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

endpackage

// File: rtl/hamming_encode_comb.sv
// Purely combinational Hamming encoder: data word -> codeword.
// Codeword bit i carries Hamming position i+1; parity bit k sits at index
// 2^k-1; data bits fill the other indices in ascending order.
// Configuration macro: HAMMING_SECDED_EN appends overall even parity as MSB.
module hamming_encode_comb
    import hamming_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]              data,
    output logic [calc_code_w(DATA_W)-1:0] code
);

    localparam int P  = calc_parity_bits(DATA_W);
    localparam int HW = DATA_W + P;

    // Codeword index that carries data bit j.
    function automatic int data_index(input int j);
        int cnt;
        int idx;
        cnt = 0;
        idx = 0;
        for (int i = 0; i < HW; i++) begin
            if (!is_pow2(i + 1)) begin
                if (cnt == j) idx = i;
                cnt++;
            end
        end
        return idx;
    endfunction

    logic [HW-1:0] spread;
    logic [HW-1:0] base;
    logic          par;

    // Scatter data bits into their positions, then fill in each parity bit.
    always_comb begin
        spread = '0;
        par    = 1'b0;
        for (int j = 0; j < DATA_W; j++) begin
            spread[data_index(j)] = data[j];
        end
        base = spread;
        for (int k = 0; k < P; k++) begin
            par = 1'b0;
            for (int i = 0; i < HW; i++) begin
                if (((((i + 1) >> k) & 1) != 0) && !is_pow2(i + 1)) par = par ^ spread[i];
            end
            base[(1 << k) - 1] = par;
        end
`ifdef HAMMING_SECDED_EN
        code = {^base, base};
`else
        code = base;
`endif
    end

endmodule

// File: rtl/hamming_stream_encoder.sv
// Streaming Hamming encoder: accepts data words, encodes them, buffers the
// codewords in a 2-entry FIFO and counts completed output handshakes.
// Configuration macro: HAMMING_SECDED_EN (adds the overall parity bit).
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A valid producer holds its data stable until that edge. in_ready
// depends only on registered state, so there is no out_ready -> in_ready path.
module hamming_stream_encoder
    import hamming_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [calc_code_w(DATA_W)-1:0] out_code,
    input  logic                           clr_count,
    output logic [CNT_W-1:0]               cw_count
);

    localparam int CODE_W = calc_code_w(DATA_W);

    logic [CODE_W-1:0] enc_code;
    logic [CODE_W-1:0] q_head;
    logic [CODE_W-1:0] q_tail;
    logic [1:0]        occ;
    logic              live;
    logic              push;
    logic              pop;

    hamming_encode_comb #(.DATA_W(DATA_W)) u_enc (
        .data (in_data),
        .code (enc_code)
    );

    // Handshake decode; live holds in_ready low until the first edge after reset.
    always_comb begin
        in_ready  = live && (occ != 2'd2);
        out_valid = (occ != 2'd0);
        out_code  = q_head;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Two-entry FIFO: head is presented downstream, tail waits behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live   <= 1'b0;
            occ    <= 2'd0;
            q_head <= '0;
            q_tail <= '0;
        end else begin
            live <= 1'b1;
            if (push && pop) begin
                // Only reachable with one entry queued: new word becomes head.
                q_head <= enc_code;
            end else if (push) begin
                if (occ == 2'd0) q_head <= enc_code;
                else             q_tail <= enc_code;
                occ <= occ + 2'd1;
            end else if (pop) begin
                q_head <= q_tail;
                q_tail <= '0;
                occ    <= occ - 2'd1;
            end
        end
    end

    // Emitted-codeword counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cw_count <= '0;
        end else if (clr_count) begin
            cw_count <= '0;
        end else if (pop) begin
            cw_count <= cw_count + CNT_W'(1);
        end
    end

endmodule
